// File: rtl/i2s_codec_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : i2s_codec_endpoint
// Purpose  : Codec-side serial audio port. Follows master BCLK/LRCK,
//            serializes stereo samples toward the master (left-justified,
//            MSB first) and deserializes the master's stream into stereo
//            sample pairs. All serial pins are oversampled on clk.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_codec_endpoint #(
    parameter int   DATA_W   = 16,
    parameter logic LEFT_LVL = 1'b1
) (
    input  logic              clk,
    input  logic              AUD_DACLRCK,
    input  logic              bclk_in,
    input  logic              lrck_in,
    input  logic              sdata_in,
    output logic              sdata_out,
    input  logic [DATA_W-1:0] tx_l,
    input  logic [DATA_W-1:0] tx_r,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_l,
    output logic [DATA_W-1:0] rx_r,
    output logic              rx_valid,
    output logic              underrun,
    output logic              frame_err
);

    localparam int              CNT_W  = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [1:0]        r_bclk_s;
    logic [1:0]        r_lrck_s;
    logic [1:0]        r_sd_s;
    logic              r_bclk_d;
    logic              r_lrck_cap;
    logic              r_cap_valid;
    logic              r_locked;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_hold_r;
    logic [DATA_W-1:0] r_active_r;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_tx_cnt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-2:0] r_rx_shift;
    logic [DATA_W-1:0] r_stage_l;
    logic              r_have_l;
    logic              r_chan_l;
    logic              r_rx_pend;

    logic              w_lrck;
    logic              w_bclk_rise;
    logic              w_bclk_fall;
    logic              w_start;
    logic              w_left_start;
    logic              w_accept;
    logic [DATA_W-1:0] w_left_word;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_rx_word;

    // Edges are judged on synchronized levels; the first fall after reset only
    // records LRCK so a reset in mid-slot cannot fake a channel start.
    assign w_lrck       = r_lrck_s[1];
    assign w_bclk_rise  = r_bclk_s[1] & ~r_bclk_d;
    assign w_bclk_fall  = ~r_bclk_s[1] & r_bclk_d;
    assign w_start      = w_bclk_fall & r_cap_valid & (w_lrck != r_lrck_cap);
    assign w_left_start = w_start & (w_lrck == LEFT_LVL);
    assign w_accept     = tx_valid & ~r_hold_full;
    assign tx_ready     = ~r_hold_full;

    // Left word: held sample, else a sample offered in this very clk, else silence.
    assign w_left_word  = r_hold_full ? r_hold_l : (tx_valid ? tx_l : '0);
    assign w_word       = w_left_start ? w_left_word : r_active_r;
    assign w_rx_word    = {r_rx_shift, r_sd_s[1]};

    // Two-flop synchronizers and the delayed BCLK level for edge detection.
    always_ff @(posedge clk or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            r_bclk_s <= '0;
            r_lrck_s <= '0;
            r_sd_s   <= '0;
            r_bclk_d <= 1'b0;
        end else begin
            r_bclk_s <= {r_bclk_s[0], bclk_in};
            r_lrck_s <= {r_lrck_s[0], lrck_in};
            r_sd_s   <= {r_sd_s[0], sdata_in};
            r_bclk_d <= r_bclk_s[1];
        end
    end

    // LRCK tracking, lock, holding register and left-start sample loading.
    always_ff @(posedge clk or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            r_lrck_cap  <= 1'b0;
            r_cap_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_hold_full <= 1'b0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_active_r  <= '0;
            underrun    <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (w_bclk_fall) begin
                r_lrck_cap  <= w_lrck;
                r_cap_valid <= 1'b1;
            end
            if (w_left_start) begin
                r_locked <= 1'b1;
                if (r_hold_full) begin
                    r_active_r  <= r_hold_r;
                    r_hold_full <= 1'b0;
                end else if (tx_valid) begin
                    r_active_r <= tx_r;
                end else begin
                    r_active_r <= '0;
                    underrun   <= r_locked;
                end
            end else if (w_accept) begin
                r_hold_l    <= tx_l;
                r_hold_r    <= tx_r;
                r_hold_full <= 1'b1;
            end
        end
    end

    // Transmit shifter: load on channel start, one bit per BCLK fall, then zeros.
    always_ff @(posedge clk or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            r_shift   <= '0;
            r_tx_cnt  <= '0;
            sdata_out <= 1'b0;
        end else if (w_start && (r_locked || w_left_start)) begin
            r_shift   <= w_word << 1;
            r_tx_cnt  <= C_ONE;
            sdata_out <= w_word[DATA_W-1];
        end else if (w_bclk_fall && r_locked) begin
            if (r_tx_cnt < C_FULL) begin
                sdata_out <= r_shift[DATA_W-1];
                r_shift   <= r_shift << 1;
                r_tx_cnt  <= r_tx_cnt + C_ONE;
            end else begin
                sdata_out <= 1'b0;
            end
        end
    end

    // Receive deserializer: staging per channel, pair published after the right word.
    always_ff @(posedge clk or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_stage_l  <= '0;
            r_have_l   <= 1'b0;
            r_chan_l   <= 1'b0;
            r_rx_pend  <= 1'b0;
            rx_l       <= '0;
            rx_r       <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= r_rx_pend;
            r_rx_pend <= 1'b0;
            frame_err <= 1'b0;
            if (w_start) begin
                r_bit_cnt <= '0;
                r_chan_l  <= w_left_start;
                if (w_left_start) begin
                    r_have_l <= 1'b0;
                end
                if (r_locked && (r_bit_cnt < C_FULL)) begin
                    frame_err <= 1'b1;
                end
            end else if (w_bclk_rise && (r_bit_cnt < C_FULL)) begin
                r_rx_shift <= w_rx_word[DATA_W-2:0];
                r_bit_cnt  <= r_bit_cnt + C_ONE;
                if ((r_bit_cnt == (C_FULL - C_ONE)) && r_locked) begin
                    if (r_chan_l) begin
                        r_stage_l <= w_rx_word;
                        r_have_l  <= 1'b1;
                    end else if (r_have_l) begin
                        rx_l      <= r_stage_l;
                        rx_r      <= w_rx_word;
                        r_rx_pend <= 1'b1;
                        r_have_l  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_codec_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_codec_endpoint
// Purpose  : Master-side model driving BCLK/LRCK/data for i2s_codec_endpoint,
//            with scoreboard queues for transmitted slots and received pairs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_codec_endpoint;

    logic        clk;
    logic        AUD_DACLRCK;
    logic        bclk_in;
    logic        lrck_in;
    logic        sdata_in;
    logic        sdata_out;
    logic [15:0] tx_l;
    logic [15:0] tx_r;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_l;
    logic [15:0] rx_r;
    logic        rx_valid;
    logic        underrun;
    logic        frame_err;

    int          n_checks;
    int          n_errors;
    int          und_seen;
    int          fe_seen;
    logic [15:0] exp_tx[$];
    logic [31:0] exp_rx[$];
    logic [31:0] last_rx;

    logic        mon_en;
    logic        mon_lr;
    int          mon_k;
    logic [15:0] mon_obs;
    logic        mon_tail;

    i2s_codec_endpoint #(
        .DATA_W  (16),
        .LEFT_LVL(1'b1)
    ) dut (
        .clk        (clk),
        .AUD_DACLRCK(AUD_DACLRCK),
        .bclk_in    (bclk_in),
        .lrck_in    (lrck_in),
        .sdata_in   (sdata_in),
        .sdata_out  (sdata_out),
        .tx_l       (tx_l),
        .tx_r       (tx_r),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_l       (rx_l),
        .rx_r       (rx_r),
        .rx_valid   (rx_valid),
        .underrun   (underrun),
        .frame_err  (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // One BCLK period (80 ns): fall with new LRCK/data, optional mid-phase action, rise.
    task automatic bclk_cycle(input logic lr, input logic sd, input int op);
        bclk_in  = 1'b0;
        lrck_in  = lr;
        sdata_in = sd;
        if (op == 1) begin
            #20 tx_valid = 1'b1;
            #10 tx_valid = 1'b0;
            #10;
        end else if (op == 2) begin
            #27 AUD_DACLRCK = 1'b0;
            #5;
            check1("rst_sdata_out", {31'd0, sdata_out}, 32'd0);
            check1("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
            check1("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
            check1("rst_rx_pair", {rx_l, rx_r}, 32'd0);
            #5 AUD_DACLRCK = 1'b1;
            #3;
        end else begin
            #40;
        end
        bclk_in = 1'b1;
        #40;
    endtask

    // 32-BCLK left slot, nr-BCLK right slot. mode 1: bypass offer at left start,
    // mode 2: reset pulse inside left bit 6, mode 3: tx_ready check after left start.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nr, input int mode);
        for (int i = 0; i < 32; i++) begin
            bclk_cycle(1'b1, (i < 16) ? l[15-i] : 1'b0,
                       (i == 0 && mode == 1) ? 1 : ((i == 6 && mode == 2) ? 2 : 0));
            if (i == 0 && mode == 3) begin
                check1("ready_after_left_start", {31'd0, tx_ready}, 32'd1);
            end
        end
        for (int i = 0; i < nr; i++) begin
            bclk_cycle(1'b0, (i < 16) ? r[15-i] : 1'b0, 0);
        end
    endtask

    task automatic accept(input logic [15:0] l, input logic [15:0] r);
        int n;
        tx_l = l;
        tx_r = r;
        n    = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (tx_ready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: tx_ready=%b expected 1", tx_ready);
        end else begin
            tx_valid = 1'b1;
            @(posedge clk);
            #1 tx_valid = 1'b0;
            @(negedge clk);
            check1("ready_low_after_accept", {31'd0, tx_ready}, 32'd0);
        end
    endtask

    // Master-side capture of sdata_out on BCLK rises; compares each full slot.
    always @(posedge bclk_in) begin
        if (mon_en) begin
            if (lrck_in !== mon_lr) begin
                mon_lr   = lrck_in;
                mon_k    = 0;
                mon_tail = 1'b0;
            end
            if (mon_k < 16) mon_obs = {mon_obs[14:0], sdata_out};
            else            mon_tail = mon_tail | sdata_out;
            if (mon_k == 15) begin
                n_checks++;
                if (exp_tx.size() == 0) begin
                    n_errors++;
                    $display("FAIL tx_slot_unexpected: got %h expected none", mon_obs);
                end else begin
                    logic [15:0] e;
                    e = exp_tx.pop_front();
                    if (mon_obs !== e) begin
                        n_errors++;
                        $display("FAIL tx_slot: got %h expected %h", mon_obs, e);
                    end
                end
            end
            if (mon_k == 31) begin
                n_checks++;
                if (mon_tail !== 1'b0) begin
                    n_errors++;
                    $display("FAIL tx_tail_zero: got %b expected 0", mon_tail);
                end
            end
            mon_k++;
        end
    end

    // Received pairs, underrun and frame-error pulses.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rx_valid === 1'b1) begin
                n_checks++;
                if (exp_rx.size() == 0) begin
                    n_errors++;
                    $display("FAIL rx_unexpected: got %h expected none", {rx_l, rx_r});
                end else begin
                    logic [31:0] e;
                    e       = exp_rx.pop_front();
                    last_rx = e;
                    if ({rx_l, rx_r} !== e) begin
                        n_errors++;
                        $display("FAIL rx_pair: got %h expected %h", {rx_l, rx_r}, e);
                    end
                end
            end
            if (underrun === 1'b1) und_seen++;
            if (frame_err === 1'b1) begin
                fe_seen++;
                n_checks++;
                if ({rx_l, rx_r} !== last_rx) begin
                    n_errors++;
                    $display("FAIL rx_hold_on_frame_err: got %h expected %h", {rx_l, rx_r}, last_rx);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        und_seen    = 0;
        fe_seen     = 0;
        last_rx     = 32'd0;
        mon_en      = 1'b0;
        mon_lr      = 1'b0;
        mon_k       = 0;
        mon_obs     = 16'd0;
        mon_tail    = 1'b0;
        AUD_DACLRCK = 1'b0;
        bclk_in     = 1'b1;
        lrck_in     = 1'b0;
        sdata_in    = 1'b0;
        tx_l        = 16'd0;
        tx_r        = 16'd0;
        tx_valid    = 1'b0;

        #30;
        check1("reset_sdata_out", {31'd0, sdata_out}, 32'd0);
        check1("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        check1("reset_pulses", {29'd0, rx_valid, underrun, frame_err}, 32'd0);
        check1("reset_rx_pair", {rx_l, rx_r}, 32'd0);
        #10 AUD_DACLRCK = 1'b1;
        #20 mon_en = 1'b1;

        // F1: held sample A5C3/0F0F out, 8001/7FFE in.
        accept(16'hA5C3, 16'h0F0F);
        for (int i = 0; i < 4; i++) bclk_cycle(1'b0, 1'b0, 0);
        exp_tx.push_back(16'hA5C3); exp_tx.push_back(16'h0F0F);
        exp_rx.push_back({16'h8001, 16'h7FFE});
        send_frame(16'h8001, 16'h7FFE, 32, 3);

        // F2: nothing offered -> underrun and silent slots.
        exp_tx.push_back(16'h0000); exp_tx.push_back(16'h0000);
        exp_rx.push_back({16'h1111, 16'h2222});
        send_frame(16'h1111, 16'h2222, 32, 0);

        // F3: recovery with 1234/5678.
        accept(16'h1234, 16'h5678);
        exp_tx.push_back(16'h1234); exp_tx.push_back(16'h5678);
        exp_rx.push_back({16'h0000, 16'hFFFF});
        send_frame(16'h0000, 16'hFFFF, 32, 3);

        // F4: FFFF/0001 offered only in the left-start clk -> bypass.
        tx_l = 16'hFFFF;
        tx_r = 16'h0001;
        exp_tx.push_back(16'hFFFF); exp_tx.push_back(16'h0001);
        exp_rx.push_back({16'hA5A5, 16'h5A5A});
        send_frame(16'hA5A5, 16'h5A5A, 32, 1);

        // F5: underrun again, right slot cut to 10 BCLK -> frame error, no pair.
        exp_tx.push_back(16'h0000);
        send_frame(16'h1357, 16'h9BDF, 10, 0);

        // F6: normal frame after the error.
        accept(16'h0BAD, 16'hF00D);
        exp_tx.push_back(16'h0BAD); exp_tx.push_back(16'hF00D);
        exp_rx.push_back({16'h0F0F, 16'hF0F0});
        send_frame(16'h0F0F, 16'hF0F0, 32, 3);

        // F7: reset during left bit 6; only the first six bits of 1234 leave.
        accept(16'h1234, 16'h4321);
        exp_tx.push_back(16'h1000); exp_tx.push_back(16'h0000);
        send_frame(16'hFFFF, 16'hFFFF, 32, 2);

        // F8: relock at the fresh left start.
        accept(16'hC0DE, 16'hBEEF);
        exp_tx.push_back(16'hC0DE); exp_tx.push_back(16'hBEEF);
        exp_rx.push_back({16'h2468, 16'h1357});
        send_frame(16'h2468, 16'h1357, 32, 0);

        #200;
        check1("tx_queue_drained", exp_tx.size(), 32'd0);
        check1("rx_queue_drained", exp_rx.size(), 32'd0);
        check1("underrun_count", und_seen, 32'd2);
        check1("frame_err_count", fe_seen, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
